// File: rtl/mmio_if.sv
// Host-to-device MMIO request/acknowledge bus: independent read and write
// channels. The host holds req, index and data stable until ack.
interface mmio_if #(
  parameter int TIA_MMIO_INDEX_WIDTH = 8,
  parameter int TIA_MMIO_DATA_WIDTH  = 32
);
  logic                            read_req;
  logic                            read_ack;
  logic [TIA_MMIO_INDEX_WIDTH-1:0] read_index;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  read_data;
  logic                            write_req;
  logic                            write_ack;
  logic [TIA_MMIO_INDEX_WIDTH-1:0] write_index;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data;

  modport device (
    input  read_req, read_index, write_req, write_index, write_data,
    output read_ack, read_data, write_ack
  );

  modport host (
    output read_req, read_index, write_req, write_index, write_data,
    input  read_ack, read_data, write_ack
  );
endinterface

// File: rtl/mmio_control_register_bank.sv
// MMIO register bank for the TIA core: control/status/scratch/argument/result registers.
// Define TIA_MMIO_CYCLE_COUNTER_EN to build the CYCLE_COUNT register (index 2); otherwise it reads 0.
//
// state        | meaning
// IDLE         | waiting for a request; write_req wins over read_req
// WRITE_ACK    | register update lands at the end of this cycle, write_ack high
// READ_ACK     | read_data holds the captured value, read_ack high
// WAIT_RELEASE | waiting for the serviced req to drop
module mmio_control_register_bank #(
  parameter int TIA_MMIO_INDEX_WIDTH = 8,
  parameter int TIA_MMIO_DATA_WIDTH  = 32,
  parameter int NUM_ARGUMENTS        = 4,
  parameter int NUM_RESULTS          = 4,
  parameter logic [TIA_MMIO_DATA_WIDTH-1:0] UNMAPPED_READ_VALUE = TIA_MMIO_DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                                       S_AXI_ACLK,
  input  logic                                       S_AXI_ARESETN,
  mmio_if.device                                     device_interface,
  output logic                                       execute,
  output logic                                       core_soft_reset,
  input  logic                                       core_halted,
  output logic [NUM_ARGUMENTS*TIA_MMIO_DATA_WIDTH-1:0] arguments,
  input  logic [NUM_RESULTS*TIA_MMIO_DATA_WIDTH-1:0]   results
);

  localparam int IW       = TIA_MMIO_INDEX_WIDTH;
  localparam int DW       = TIA_MMIO_DATA_WIDTH;
  localparam int ARG_BASE = 4;
  localparam int RES_BASE = ARG_BASE + NUM_ARGUMENTS;

  typedef enum logic [1:0] {IDLE, WRITE_ACK, READ_ACK, WAIT_RELEASE} state_t;

  state_t  state_q, state_d;
  logic    serv_wr_q, serv_wr_d;
  logic    wr_en, rd_load, read_ack_c, write_ack_c;

  logic [IW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] wr_data;

  logic          execute_q, soft_reset_q, done_sticky_q, halted_q;
  logic [DW-1:0] scratch_q;
  logic [DW-1:0] arg_q [NUM_ARGUMENTS];
  logic [DW-1:0] rd_mux, rd_data_q, cycle_val;

  logic wr_ctrl, wr_status, wr_scratch, done_set;

  assign wr_idx  = device_interface.write_index;
  assign rd_idx  = device_interface.read_index;
  assign wr_data = device_interface.write_data;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= IDLE;
      serv_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      serv_wr_q <= serv_wr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    serv_wr_d   = serv_wr_q;
    wr_en       = 1'b0;
    rd_load     = 1'b0;
    read_ack_c  = 1'b0;
    write_ack_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (device_interface.write_req) begin
          state_d   = WRITE_ACK;
          serv_wr_d = 1'b1;
        end else if (device_interface.read_req) begin
          state_d   = READ_ACK;
          serv_wr_d = 1'b0;
          rd_load   = 1'b1;
        end
      end
      WRITE_ACK: begin
        wr_en       = 1'b1;
        write_ack_c = 1'b1;
        state_d     = WAIT_RELEASE;
      end
      READ_ACK: begin
        read_ack_c = 1'b1;
        state_d    = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // Only the serviced channel gates release; the other req may stay pending.
        if (serv_wr_q ? !device_interface.write_req : !device_interface.read_req)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ctrl    = wr_en && (wr_idx == IW'(0));
  assign wr_status  = wr_en && (wr_idx == IW'(1));
  assign wr_scratch = wr_en && (wr_idx == IW'(3));
  assign done_set   = core_halted && !halted_q && execute_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      execute_q     <= 1'b0;
      soft_reset_q  <= 1'b0;
      done_sticky_q <= 1'b0;
      halted_q      <= 1'b0;
      scratch_q     <= '0;
      for (int i = 0; i < NUM_ARGUMENTS; i++) arg_q[i] <= '0;
    end else begin
      halted_q     <= core_halted;
      soft_reset_q <= wr_ctrl && wr_data[1];
      if (wr_ctrl) execute_q <= wr_data[0];
      if (wr_scratch) scratch_q <= wr_data;
      for (int i = 0; i < NUM_ARGUMENTS; i++) begin
        if (wr_en && (wr_idx == IW'(ARG_BASE + i))) arg_q[i] <= wr_data;
      end
      // A halt edge in the same cycle as a STATUS write keeps the flag set.
      if (done_set) done_sticky_q <= 1'b1;
      else if (wr_status) done_sticky_q <= 1'b0;
    end
  end

`ifdef TIA_MMIO_CYCLE_COUNTER_EN
  logic [DW-1:0] cycle_cnt_q;
  logic          cnt_clr;

  assign cnt_clr = soft_reset_q || (wr_ctrl && wr_data[0] && !execute_q);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) cycle_cnt_q <= '0;
    else if (cnt_clr) cycle_cnt_q <= '0;
    else if (execute_q && !core_halted) cycle_cnt_q <= cycle_cnt_q + DW'(1);
  end

  assign cycle_val = cycle_cnt_q;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    rd_mux = UNMAPPED_READ_VALUE;
    if (rd_idx == IW'(0))      rd_mux = {{(DW-1){1'b0}}, execute_q};
    else if (rd_idx == IW'(1)) rd_mux = {{(DW-3){1'b0}}, done_sticky_q, execute_q, core_halted};
    else if (rd_idx == IW'(2)) rd_mux = cycle_val;
    else if (rd_idx == IW'(3)) rd_mux = scratch_q;
    for (int i = 0; i < NUM_ARGUMENTS; i++) begin
      if (rd_idx == IW'(ARG_BASE + i)) rd_mux = arg_q[i];
    end
    for (int i = 0; i < NUM_RESULTS; i++) begin
      if (rd_idx == IW'(RES_BASE + i)) rd_mux = results[i*DW +: DW];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rd_data_q <= '0;
    else if (rd_load) rd_data_q <= rd_mux;
  end

  assign device_interface.read_ack  = read_ack_c;
  assign device_interface.write_ack = write_ack_c;
  assign device_interface.read_data = rd_data_q;
  assign execute         = execute_q;
  assign core_soft_reset = soft_reset_q;

  for (genvar g = 0; g < NUM_ARGUMENTS; g++) begin : g_args
    assign arguments[g*DW +: DW] = arg_q[g];
  end

endmodule

// File: tb/tb_mmio_control_register_bank.sv
// Scoreboard bench for mmio_control_register_bank: stimulus queues expected read
// data, a negedge monitor pops and compares on every ack.
module tb_mmio_control_register_bank;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int NA = 4;
  localparam int NR = 4;

  typedef struct {
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    string         name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_halted;
  logic execute, core_soft_reset;
  logic [NA*DW-1:0] arguments;
  logic [NR*DW-1:0] results;

  always #5 clk = ~clk;

  mmio_if #(.TIA_MMIO_INDEX_WIDTH(IW), .TIA_MMIO_DATA_WIDTH(DW)) bus ();

  mmio_control_register_bank #(
    .TIA_MMIO_INDEX_WIDTH(IW), .TIA_MMIO_DATA_WIDTH(DW),
    .NUM_ARGUMENTS(NA), .NUM_RESULTS(NR), .UNMAPPED_READ_VALUE(32'hDEAD_BEEF)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .device_interface(bus),
    .execute(execute), .core_soft_reset(core_soft_reset), .core_halted(core_halted),
    .arguments(arguments), .results(results)
  );

  int   total = 0, bad = 0;
  exp_t rq[$];
  int   pending_wr = 0, n_rd = 0, n_wr = 0;
  int   rd_ack_cnt = 0, wr_ack_cnt = 0;
  int   cyc = 0, wack_cyc = 0, sr_cyc = 0, sr_count = 0;
  int   last_lat = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (bus.write_ack) begin
        wr_ack_cnt++;
        wack_cyc = cyc;
        total++;
        if (pending_wr == 0) begin
          bad++;
          $display("FAIL unexpected_write_ack actual=1 required=0");
        end else pending_wr--;
      end
      if (bus.read_ack) begin
        rd_ack_cnt++;
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read_ack actual=%h required=none", bus.read_data);
        end else begin
          exp_t e;
          e = rq.pop_front();
          if (bus.read_data < e.lo || bus.read_data > e.hi) begin
            bad++;
            $display("FAIL %s actual=%h required=%h..%h", e.name, bus.read_data, e.lo, e.hi);
          end
        end
      end
      if (core_soft_reset) begin
        sr_count++;
        sr_cyc = cyc;
      end
    end
  end

  task automatic wait_ack(input bit is_wr, input bit drop);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (is_wr ? bus.write_ack : bus.read_ack) got = 1'b1;
      else n++;
    end
    last_lat = n;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout actual=none required=%s_ack", is_wr ? "write" : "read");
    end
    @(posedge clk);
    #1;
    if (drop) begin
      if (is_wr) bus.write_req = 1'b0;
      else bus.read_req = 1'b0;
    end
  endtask

  task automatic do_write(input logic [IW-1:0] idx, input logic [DW-1:0] data);
    @(posedge clk);
    #1;
    bus.write_index = idx;
    bus.write_data  = data;
    bus.write_req   = 1'b1;
    pending_wr++;
    n_wr++;
    wait_ack(1'b1, 1'b1);
  endtask

  task automatic do_read(input logic [IW-1:0] idx, input logic [DW-1:0] lo,
                         input logic [DW-1:0] hi, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    e.lo = lo;
    e.hi = hi;
    e.name = name;
    rq.push_back(e);
    n_rd++;
    bus.read_index = idx;
    bus.read_req   = 1'b1;
    wait_ack(1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sr_base;
    exp_t e;
    bus.read_req = 1'b0;
    bus.write_req = 1'b0;
    bus.read_index = '0;
    bus.write_index = '0;
    bus.write_data = '0;
    core_halted = 1'b0;
    results = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("rst_read_ack", {31'b0, bus.read_ack}, 0);
    check("rst_write_ack", {31'b0, bus.write_ack}, 0);
    check("rst_read_data", bus.read_data, 0);
    check("rst_execute", {31'b0, execute}, 0);
    check("rst_soft_reset", {31'b0, core_soft_reset}, 0);
    check("rst_arg0", arguments[31:0], 0);
    rst_n = 1'b1;

    do_read(3, 0, 0, "scratch_reset");
    check("read_latency", last_lat, 1);
    do_write(3, 32'h1234_5678);
    do_read(3, 32'h1234_5678, 32'h1234_5678, "scratch_rb");

    do_write(4, 32'hA5A5_0001);
    check("arg0_after_write", arguments[31:0], 32'hA5A5_0001);
    do_read(4, 32'hA5A5_0001, 32'hA5A5_0001, "arg0_rb");
    do_read(7, 0, 0, "arg3_rb");
    do_read(8, 32'h5000_0000, 32'h5000_0000, "result0");
    do_read(11, 32'h5000_0003, 32'h5000_0003, "result3");
    do_read(12, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "unmapped12");
    do_read(63, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "unmapped63");
    do_write(63, 32'hFFFF_FFFF);
    do_write(8, 32'h0);
    do_write(2, 32'h55);
    check("args_after_ro_writes_lo", arguments[31:0], 32'hA5A5_0001);
    check("args_after_ro_writes_hi", arguments[127:96] | arguments[95:64] | arguments[63:32], 0);
    do_read(3, 32'h1234_5678, 32'h1234_5678, "scratch_after_unmapped");
    do_read(8, 32'h5000_0000, 32'h5000_0000, "result0_after_write");
    do_read(2, 0, 0, "cycle_idle");
    do_read(0, 0, 0, "control_reset");

    sr_base = sr_count;
    do_write(0, 32'h3);
    check("execute_set", {31'b0, execute}, 1);
    repeat (10) @(posedge clk);
    check("soft_reset_len", sr_count - sr_base, 1);
    check("soft_reset_start", sr_cyc - wack_cyc, 1);
`ifdef TIA_MMIO_CYCLE_COUNTER_EN
    do_read(2, 9, 11, "cycle_count");
`else
    do_read(2, 0, 0, "cycle_count");
`endif
    do_read(0, 1, 1, "control_rb");

    core_halted = 1'b1;
    do_read(1, 32'h7, 32'h7, "status_done");
    do_write(1, 32'h0);
    do_read(1, 32'h3, 32'h3, "status_cleared");
    core_halted = 1'b0;
    do_read(1, 32'h2, 32'h2, "status_running");
    @(posedge clk);
    #1;
    bus.write_index = 1;
    bus.write_data  = 32'h0;
    bus.write_req   = 1'b1;
    pending_wr++;
    n_wr++;
    @(posedge clk);
    #1;
    core_halted = 1'b1;
    wait_ack(1'b1, 1'b1);
    do_read(1, 32'h7, 32'h7, "status_set_beats_clear");

    @(posedge clk);
    #1;
    bus.write_index = 3;
    bus.write_data  = 32'h0000_CAFE;
    bus.read_index  = 3;
    bus.write_req   = 1'b1;
    bus.read_req    = 1'b1;
    e.lo = 32'h0000_CAFE;
    e.hi = 32'h0000_CAFE;
    e.name = "simul_read";
    rq.push_back(e);
    pending_wr++;
    n_wr++;
    n_rd++;
    wait_ack(1'b1, 1'b1);
    wait_ack(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.read_req = 1'b0;

    @(posedge clk);
    #1;
    bus.read_index = 3;
    bus.read_req   = 1'b1;
    @(posedge clk);
    #1;
    check("ack_before_reset", {31'b0, bus.read_ack}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_read_ack", {31'b0, bus.read_ack}, 0);
    check("midrst_read_data", bus.read_data, 0);
    check("midrst_execute", {31'b0, execute}, 0);
    check("midrst_arg0", arguments[31:0], 0);
    bus.read_req = 1'b0;
    core_halted  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_read(3, 0, 0, "scratch_after_reset");
    do_read(1, 0, 0, "status_after_reset");

    repeat (3) @(posedge clk);
    check("read_queue_empty", rq.size(), 0);
    check("write_pending_zero", pending_wr, 0);
    check("read_ack_count", rd_ack_cnt, n_rd);
    check("write_ack_count", wr_ack_cnt, n_wr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
